sram_init_seq: RTL and testbench

- Sits between an N15_SoC SRAM port (CP or NB) and its SRAM macro inside the chip core.
- After reset it fills every SRAM word with a fixed pattern, then optionally reads each word back and checks it.
- It holds the SoC in reset for that whole time. Once done it becomes a transparent pass-through and releases the SoC.
- It guarantees deterministic SRAM contents at boot and gives a basic memory self-check.

---
 rtl/sram_init_seq.sv | 169 ++++++++++++++++
 tb/tb_sram_init_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_init_seq.sv
// sram_init_seq: fills an SRAM macro with a fixed pattern after reset,
// optionally reads every word back and checks it, and holds the SoC in
// reset until the sequence has finished. Afterwards the SoC port is
// connected straight through to the macro.
module sram_init_seq #(
    parameter int          AW        = 12,
    parameter logic [31:0] FILL_WORD = 32'h0000_0000,
    parameter bit          VERIFY    = 1'b1
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          SRAMCS,
    input  logic [3:0]    SRAMWEN,
    input  logic [31:0]   SRAMWDATA,
    input  logic [AW-3:0] SRAMADDR,
    output logic [31:0]   SRAMRDATA,
    output logic          M_SRAMCS,
    output logic [3:0]    M_SRAMWEN,
    output logic [31:0]   M_SRAMWDATA,
    output logic [AW-3:0] M_SRAMADDR,
    input  logic [31:0]   M_SRAMRDATA,
    output logic          SOC_HRESETn,
    output logic          INIT_DONE,
    output logic          INIT_FAIL,
    output logic [AW-3:0] FAIL_ADDR
);

    localparam int WAW   = AW - 2;
    localparam int DEPTH = 2 ** WAW;

    // Counter is one bit wider than the word address so the verify pass can
    // spend one extra cycle (count == DEPTH) on the final pipelined compare.
    localparam logic [WAW:0] CNT_LAST_FILL  = (WAW + 1)'(DEPTH - 1);
    localparam logic [WAW:0] CNT_END_VERIFY = (WAW + 1)'(DEPTH);
    localparam logic [WAW:0] CNT_ONE        = (WAW + 1)'(1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [WAW:0]   cnt_reg, cnt_next;

    // Macro-side access generated by the sequencer (registered).
    logic           init_cs_reg, init_cs_next;
    logic [3:0]     init_wen_reg, init_wen_next;
    logic [31:0]    init_wdata_reg, init_wdata_next;
    logic [WAW-1:0] init_addr_reg, init_addr_next;

    // Read-back compare pipeline: the read presented in the previous cycle.
    logic           cmp_vld_reg;
    logic [WAW-1:0] cmp_addr_reg;
    logic           cmp_miss;

    logic           fail_reg;
    logic [WAW-1:0] fail_addr_reg;
    logic           done_reg;
    logic           soc_rst_n_reg;

    // State and access registers; reset restarts the whole sequence at word 0.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg      <= ST_FILL;
            cnt_reg        <= '0;
            init_cs_reg    <= 1'b0;
            init_wen_reg   <= 4'h0;
            init_wdata_reg <= 32'h0;
            init_addr_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            init_cs_reg    <= init_cs_next;
            init_wen_reg   <= init_wen_next;
            init_wdata_reg <= init_wdata_next;
            init_addr_reg  <= init_addr_next;
        end
    end

    // Next state, address counter and the macro access for the coming cycle.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        init_cs_next    = 1'b0;
        init_wen_next   = 4'h0;
        init_wdata_next = 32'h0;
        init_addr_next  = '0;
        case (state_reg)
            ST_FILL: begin
                init_cs_next    = 1'b1;
                init_wen_next   = 4'hF;
                init_wdata_next = FILL_WORD;
                init_addr_next  = cnt_reg[WAW-1:0];
                if (cnt_reg == CNT_LAST_FILL) begin
                    cnt_next   = '0;
                    state_next = VERIFY ? ST_VERIFY : ST_DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            ST_VERIFY: begin
                if (cnt_reg == CNT_END_VERIFY) begin
                    // Compare-only cycle for the last read; no access issued.
                    cnt_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    init_cs_next   = 1'b1;
                    init_addr_next = cnt_reg[WAW-1:0];
                    cnt_next       = cnt_reg + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_FILL;
                cnt_next   = '0;
            end
        endcase
    end

    // Read data for the previous read is on M_SRAMRDATA this cycle.
    assign cmp_miss = cmp_vld_reg && (M_SRAMRDATA != FILL_WORD);

    // Compare pipeline and sticky first-failure capture.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cmp_vld_reg   <= 1'b0;
            cmp_addr_reg  <= '0;
            fail_reg      <= 1'b0;
            fail_addr_reg <= '0;
        end else begin
            cmp_vld_reg  <= init_cs_reg && (init_wen_reg == 4'h0);
            cmp_addr_reg <= init_addr_reg;
            if (cmp_miss && !fail_reg) begin
                fail_reg      <= 1'b1;
                fail_addr_reg <= cmp_addr_reg;
            end
        end
    end

    // Completion flag, then SoC reset release one cycle later.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            done_reg      <= 1'b0;
            soc_rst_n_reg <= 1'b0;
        end else begin
            if (state_reg == ST_DONE) begin
                done_reg <= 1'b1;
            end
            soc_rst_n_reg <= done_reg;
        end
    end

    // Pass-through is purely combinational once done so the SoC sees no
    // extra latency; before that the SoC side is ignored and reads as zero.
    assign M_SRAMCS    = done_reg ? SRAMCS    : init_cs_reg;
    assign M_SRAMWEN   = done_reg ? SRAMWEN   : init_wen_reg;
    assign M_SRAMWDATA = done_reg ? SRAMWDATA : init_wdata_reg;
    assign M_SRAMADDR  = done_reg ? SRAMADDR  : init_addr_reg;
    assign SRAMRDATA   = done_reg ? M_SRAMRDATA : 32'h0;

    assign SOC_HRESETn = soc_rst_n_reg;
    assign INIT_DONE   = done_reg;
    assign INIT_FAIL   = fail_reg;
    assign FAIL_ADDR   = fail_addr_reg;

endmodule

// File: tb/tb_sram_init_seq.sv
// tb_sram_init_seq: scoreboard bench for sram_init_seq with a 4-word SRAM
// model that can flip bit 0 of selected words on read.
module tb_sram_init_seq;

    localparam logic [31:0] FW = 32'hA5A5_5A5A;

    typedef logic [75:0] snap_t;

    logic        HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        rst_n;
    logic        rst_nv_n;

    logic        soc_cs;
    logic [3:0]  soc_wen;
    logic [31:0] soc_wdata;
    logic [1:0]  soc_addr;

    logic [31:0] soc_rdata;
    logic        m_cs;
    logic [3:0]  m_wen;
    logic [31:0] m_wdata;
    logic [1:0]  m_addr;
    logic [31:0] m_rdata;
    logic        soc_rst_n;
    logic        init_done;
    logic        init_fail;
    logic [1:0]  fail_addr;

    logic [31:0] nv_soc_rdata;
    logic        nv_m_cs;
    logic [3:0]  nv_m_wen;
    logic [31:0] nv_m_wdata;
    logic [1:0]  nv_m_addr;
    logic [31:0] nv_m_rdata;
    logic        nv_soc_rst_n;
    logic        nv_init_done;
    logic        nv_init_fail;
    logic [1:0]  nv_fail_addr;

    sram_init_seq #(.AW(4), .FILL_WORD(FW), .VERIFY(1'b1)) dut (
        .HCLK(HCLK), .HRESETn(rst_n),
        .SRAMCS(soc_cs), .SRAMWEN(soc_wen), .SRAMWDATA(soc_wdata), .SRAMADDR(soc_addr),
        .SRAMRDATA(soc_rdata),
        .M_SRAMCS(m_cs), .M_SRAMWEN(m_wen), .M_SRAMWDATA(m_wdata), .M_SRAMADDR(m_addr),
        .M_SRAMRDATA(m_rdata),
        .SOC_HRESETn(soc_rst_n), .INIT_DONE(init_done), .INIT_FAIL(init_fail),
        .FAIL_ADDR(fail_addr)
    );

    sram_init_seq #(.AW(4), .FILL_WORD(FW), .VERIFY(1'b0)) dut_nv (
        .HCLK(HCLK), .HRESETn(rst_nv_n),
        .SRAMCS(soc_cs), .SRAMWEN(soc_wen), .SRAMWDATA(soc_wdata), .SRAMADDR(soc_addr),
        .SRAMRDATA(nv_soc_rdata),
        .M_SRAMCS(nv_m_cs), .M_SRAMWEN(nv_m_wen), .M_SRAMWDATA(nv_m_wdata),
        .M_SRAMADDR(nv_m_addr), .M_SRAMRDATA(nv_m_rdata),
        .SOC_HRESETn(nv_soc_rst_n), .INIT_DONE(nv_init_done), .INIT_FAIL(nv_init_fail),
        .FAIL_ADDR(nv_fail_addr)
    );

    // Synchronous SRAM model: byte writes, read data one cycle later,
    // optional bit-0 flip on read for words marked faulty.
    logic [31:0] mem [0:3];
    logic [3:0]  fault;
    always @(posedge HCLK) begin
        if (m_cs) begin
            if (m_wen != 4'h0) begin
                for (int b = 0; b < 4; b++)
                    if (m_wen[b]) mem[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
            end else begin
                m_rdata <= mem[m_addr] ^ {31'b0, fault[m_addr]};
            end
        end
    end

    int    checks = 0;
    int    errors = 0;
    snap_t exp_q[$];
    logic [127:0] exp_v[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("txn %s ok: %h", tag, obs);
        end
    endtask

    function automatic snap_t pack(input logic cs, input logic [3:0] wen, input logic [1:0] addr,
                                   input logic [31:0] wd, input logic done, input logic socr,
                                   input logic fail, input logic [1:0] fa, input logic [31:0] rd);
        return {cs, wen, (cs ? addr : 2'b00), ((wen != 4'h0) ? wd : 32'h0),
                done, socr, fail, fa, rd};
    endfunction

    // SRAMRDATA is only folded in before done, where it must read as zero.
    function automatic snap_t obs_now(input bit nv);
        if (nv)
            return pack(nv_m_cs, nv_m_wen, nv_m_addr, nv_m_wdata, nv_init_done, nv_soc_rst_n,
                        nv_init_fail, nv_fail_addr, nv_init_done ? 32'h0 : nv_soc_rdata);
        return pack(m_cs, m_wen, m_addr, m_wdata, init_done, soc_rst_n,
                    init_fail, fail_addr, init_done ? 32'h0 : soc_rdata);
    endfunction

    // Reset, then follow the init sequence cycle by cycle. Cycle c is sampled
    // on the falling edge after the c-th rising edge following reset release.
    // ffirst is the first faulty word address (-1 for none).
    task automatic run_init(input bit nv, input int ffirst, input string name);
        int ncyc;
        logic cs, done, socr, fail;
        logic [3:0] wen;
        logic [1:0] addr, fa;
        logic [31:0] wd;
        @(negedge HCLK);
        if (nv) rst_nv_n = 1'b0; else rst_n = 1'b0;
        repeat (2) @(negedge HCLK);
        exp_q.push_back(pack(1'b0, 4'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0));
        check($sformatf("%s_reset", name), 128'(obs_now(nv)), 128'(exp_q.pop_front()));
        ncyc = nv ? 7 : 11;
        for (int c = 1; c <= ncyc; c++) begin
            cs = 1'b0; wen = 4'h0; addr = 2'b00; wd = 32'h0;
            if (c <= 4) begin
                cs = 1'b1; wen = 4'hF; addr = 2'(c - 1); wd = FW;
            end else if (!nv && c <= 8) begin
                cs = 1'b1; addr = 2'(c - 5);
            end
            done = nv ? (c >= 5) : (c >= 10);
            socr = nv ? (c >= 6) : (c >= 11);
            fail = !nv && (ffirst >= 0) && (c >= 7 + ffirst);
            fa   = fail ? 2'(ffirst) : 2'b00;
            exp_q.push_back(pack(cs, wen, addr, wd, done, socr, fail, fa, 32'h0));
        end
        if (nv) rst_nv_n = 1'b1; else rst_n = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge HCLK);
            check($sformatf("%s_cyc%0d", name, c), 128'(obs_now(nv)), 128'(exp_q.pop_front()));
        end
    endtask

    initial begin
        rst_n = 1'b0; rst_nv_n = 1'b0;
        soc_cs = 1'b0; soc_wen = 4'h0; soc_wdata = 32'h0; soc_addr = 2'b00;
        fault = 4'b0000;
        nv_m_rdata = 32'h0;
        m_rdata = 32'h0;

        // Fill without read-back: done one cycle after the last write.
        run_init(1'b1, -1, "noverify");

        // Clean fill + verify.
        run_init(1'b0, -1, "clean");

        // Single faulty word at address 2; word 3 is still read.
        fault = 4'b0100;
        run_init(1'b0, 2, "fault2");

        // Two faulty words: first failing address is kept.
        fault = 4'b1010;
        run_init(1'b0, 1, "fault13");

        // Reset mid-verify after a mismatch has been recorded at word 0.
        fault = 4'b0001;
        @(negedge HCLK);
        rst_n = 1'b0;
        repeat (2) @(negedge HCLK);
        rst_n = 1'b1;
        repeat (7) @(negedge HCLK);
        exp_v.push_back(128'(3'b100));
        check("midverify_fail", 128'({init_fail, fail_addr}), exp_v.pop_front());
        #2 rst_n = 1'b0;
        #1;
        exp_v.push_back(128'h0);
        check("async_reset", 128'({soc_rst_n, init_done, init_fail, fail_addr, m_cs}),
              exp_v.pop_front());
        fault = 4'b0000;
        run_init(1'b0, -1, "restart");

        // Pass-through: SoC write then read of word 1, seen by the macro
        // in the same cycle.
        @(negedge HCLK);
        soc_cs = 1'b1; soc_wen = 4'h3; soc_wdata = 32'h1234_5678; soc_addr = 2'd1;
        exp_v.push_back(128'({1'b1, 4'h3, 32'h1234_5678, 2'd1}));
        #1 check("pt_write", 128'({m_cs, m_wen, m_wdata, m_addr}), exp_v.pop_front());
        @(negedge HCLK);
        soc_wen = 4'h0; soc_wdata = 32'h0;
        exp_v.push_back(128'({1'b1, 4'h0, 2'd1}));
        #1 check("pt_read", 128'({m_cs, m_wen, m_addr}), exp_v.pop_front());
        @(negedge HCLK);
        soc_cs = 1'b0; soc_addr = 2'd0;
        exp_v.push_back(128'(32'hA5A5_5678));
        check("pt_rdata", 128'(soc_rdata), exp_v.pop_front());
        repeat (3) @(negedge HCLK);
        exp_v.push_back(128'({1'b1, 1'b1, 1'b0}));
        check("stay_done", 128'({init_done, soc_rst_n, init_fail}), exp_v.pop_front());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
